// File: rtl/gcd_pkg.sv
// Shared constants for the GCD arbiter: datapath width, FSM state encoding
// and a small helper for wrapping requester ids.
package gcd_pkg;

  localparam int GCD_W = 16;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;
  localparam logic [2:0] ABORT  = 3'd5;

  // Id that follows cur in round-robin order, wrapping at nreq-1.
  function automatic int next_rr(input int cur, input int nreq);
    return (cur >= nreq - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/gcd_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// after rr_ptr, wrapping at NREQ. "any" is low when no request is pending.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            any,
  output logic [IDW-1:0]  grant_id
);

  int idx;

  // Scan from the farthest offset down to offset 0 so the closest hit to rr_ptr wins.
  always_comb begin
    any      = 1'b0;
    grant_id = '0;
    idx      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req[idx]) begin
        any      = 1'b1;
        grant_id = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one GCD engine among NREQ requesters. One job is in flight at a time:
// the winner's operands are captured in IDLE, streamed to the engine as A then
// B, and the result (or a watchdog abort) is returned tagged with its id.
//
// Handshake: a requester holds req[i] with stable operands; the capture edge is
// the IDLE->LOAD_A transition and req_ack[i] pulses for one cycle right after
// it. rsp_valid pulses for one cycle; rsp_id/rsp_data/rsp_err are valid in that
// cycle and hold their value until the next pulse.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 70000,
  parameter int TW      = 17
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*GCD_W-1:0]   req_a,
  input  logic [NREQ*GCD_W-1:0]   req_b,
  output logic [NREQ-1:0]         req_ack,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [GCD_W-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    gcd_rst,
  output logic                    gcd_irdy,
  output logic [GCD_W-1:0]        gcd_din,
  input  logic                    gcd_ordy,
  input  logic [GCD_W-1:0]        gcd_dout
);

  logic [2:0]       state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [GCD_W-1:0] a_q, a_d;
  logic [GCD_W-1:0] b_q, b_d;
  logic [TW-1:0]    wdog_q, wdog_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [GCD_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic             pick_any;
  logic [IDW-1:0]   pick_id;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req      (req),
    .rr_ptr   (rr_ptr_q),
    .any      (pick_any),
    .grant_id (pick_id)
  );

  // Next-state logic: FSM, operand capture, watchdog, response registers and rr pointer.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    wdog_d      = wdog_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          id_d    = pick_id;
          a_d     = req_a[int'(pick_id)*GCD_W +: GCD_W];
          b_d     = req_b[int'(pick_id)*GCD_W +: GCD_W];
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        state_d = LOAD_B;
      end
      LOAD_B: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + TW'(1);
        // Response registers are loaded on the way out so rsp_valid is high
        // exactly during the RESP / ABORT cycle.
        if (gcd_ordy) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = gcd_dout;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (wdog_q == TW'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = ABORT;
        end
      end
      RESP, ABORT: begin
        rr_ptr_d = IDW'(next_rr(int'(id_q), NREQ));
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; everything clears on async reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      wdog_q      <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      wdog_q      <= wdog_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Engine-side and acknowledge outputs decoded from the registered state.
  always_comb begin
    req_ack  = '0;
    gcd_irdy = 1'b0;
    gcd_din  = '0;
    gcd_rst  = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      LOAD_A: begin
        req_ack[id_q] = 1'b1;
        gcd_irdy      = 1'b1;
        gcd_din       = a_q;
      end
      LOAD_B: begin
        gcd_din = b_q;
      end
      ABORT: begin
        gcd_rst = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter with a behavioural subtract/swap GCD engine attached.
// The watchdog limit is shortened so an abort can be provoked quickly.
module tb_gcd_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 100;
  localparam int TW      = 7;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_data;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req;
  logic [NREQ*16-1:0] req_a, req_b;
  logic [NREQ-1:0]    req_ack;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_data;
  logic               rsp_err;
  logic               busy;
  logic               gcd_rst;
  logic               gcd_irdy;
  logic [15:0]        gcd_din;
  logic               gcd_ordy;
  logic [15:0]        gcd_dout;

  gcd_arbiter #(
    .NREQ    (NREQ),
    .IDW     (IDW),
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .gcd_rst   (gcd_rst),
    .gcd_irdy  (gcd_irdy),
    .gcd_din   (gcd_din),
    .gcd_ordy  (gcd_ordy),
    .gcd_dout  (gcd_dout)
  );

  // ---------------- GCD engine model ----------------
  logic [15:0] ea, eb;
  logic        eload_b, erun;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ea <= '0; eb <= '0; eload_b <= 1'b0; erun <= 1'b0;
      gcd_ordy <= 1'b0; gcd_dout <= '0;
    end else if (gcd_rst) begin
      ea <= '0; eb <= '0; eload_b <= 1'b0; erun <= 1'b0;
      gcd_ordy <= 1'b0; gcd_dout <= '0;
    end else if (gcd_irdy) begin
      ea <= gcd_din; eload_b <= 1'b1; erun <= 1'b0; gcd_ordy <= 1'b0;
    end else if (eload_b) begin
      eb <= gcd_din; eload_b <= 1'b0; erun <= 1'b1;
    end else if (erun) begin
      if (eb == 16'd0) begin
        gcd_ordy <= 1'b1; gcd_dout <= ea; erun <= 1'b0;
      end else if (ea < eb) begin
        ea <= eb; eb <= ea;
      end else begin
        ea <= ea - eb;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [IDW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    req     = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Runs one job on requester id starting from an idle DUT; operands are
  // scrambled right after the ack to show post-capture changes are ignored.
  task automatic run_job(input int id, input logic [15:0] a, input logic [15:0] b,
                         output int ack_lat, output logic [NREQ-1:0] ack_val,
                         output int rsp_lat, output logic [IDW-1:0] r_id,
                         output logic [15:0] r_data, output logic r_err,
                         output logic r_rst, output logic ok);
    ok = 1'b1; ack_lat = 0; rsp_lat = 0; ack_val = '0;
    r_id = '0; r_data = '0; r_err = 1'b0; r_rst = 1'b0;
    req_a[id*16 +: 16] = a;
    req_b[id*16 +: 16] = b;
    req[id] = 1'b1;
    do begin
      tick();
      ack_lat++;
    end while (req_ack == '0 && ack_lat < 20);
    ack_val = req_ack;
    req[id] = 1'b0;
    req_a[id*16 +: 16] = ~a;
    req_b[id*16 +: 16] = ~b;
    if (ack_val == '0) ok = 1'b0;
    if (ok) begin
      do begin
        tick();
        rsp_lat++;
      end while (!rsp_valid && rsp_lat < 400);
      if (!rsp_valid) ok = 1'b0;
      r_id = rsp_id; r_data = rsp_data; r_err = rsp_err; r_rst = gcd_rst;
      tick();
    end
  endtask

  task automatic check_job(input string name, input int id, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] exp_data,
                           input logic exp_err, input int exp_rsp_lat);
    int ack_lat, rsp_lat;
    logic [NREQ-1:0] ack_val;
    logic [IDW-1:0] r_id;
    logic [15:0] r_data;
    logic r_err, r_rst, ok;
    run_job(id, a, b, ack_lat, ack_val, rsp_lat, r_id, r_data, r_err, r_rst, ok);
    check({name, " completed"}, {31'd0, ok}, 32'd1);
    check({name, " ack latency"}, ack_lat, 32'd1);
    check({name, " ack onehot"}, {28'd0, ack_val}, 32'd1 << id);
    check({name, " rsp_id"}, {30'd0, r_id}, id);
    check({name, " rsp_data"}, {16'd0, r_data}, {16'd0, exp_data});
    check({name, " rsp_err"}, {31'd0, r_err}, {31'd0, exp_err});
    check({name, " gcd_rst"}, {31'd0, r_rst}, {31'd0, exp_err});
    if (exp_rsp_lat >= 0) check({name, " rsp latency"}, rsp_lat, exp_rsp_lat);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " ctl"}, {22'd0, busy, gcd_rst, gcd_irdy, req_ack, rsp_valid, rsp_id, rsp_err}, 32'd0);
    check({name, " buses"}, {gcd_din, rsp_data}, 32'd0);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[8];

  initial begin
    int got, gap, max_gap, grants, resps, gid;
    logic [IDW-1:0] ids[2];
    logic [15:0] datas[2];

    vecs[0] = '{0, 16'd48, 16'd18, 16'd6};
    vecs[1] = '{1, 16'd0, 16'd0, 16'd0};
    vecs[2] = '{2, 16'd7, 16'd0, 16'd7};
    vecs[3] = '{3, 16'd0, 16'd9, 16'd9};
    vecs[4] = '{0, 16'd65535, 16'd65535, 16'd65535};
    vecs[5] = '{1, 16'd1071, 16'd462, 16'd21};
    vecs[6] = '{2, 16'd17, 16'd5, 16'd1};
    vecs[7] = '{2, 16'd60000, 16'd1500, 16'd1500};

    req = '0; req_a = '0; req_b = '0;
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Directed vectors, including the edge operands.
    for (int i = 0; i < 8; i++)
      check_job($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b,
                vecs[i].exp_data, 1'b0, -1);

    // Watchdog: LOAD_A(ack) -> LOAD_B -> TIMEOUT WAIT cycles -> ABORT.
    check_job("abort", 0, 16'd65535, 16'd1, 16'd0, 1'b1, TIMEOUT + 2);
    check_job("after_abort", 1, 16'd12, 16'd8, 16'd4, 1'b0, -1);

    // Reset during WAIT drops the job silently.
    req_a[15:0] = 16'd65535; req_b[15:0] = 16'd1; req = 4'b0001;
    got = 0;
    do begin tick(); got++; end while (req_ack == '0 && got < 20);
    req = '0;
    repeat (5) tick();
    check("midjob busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("async reset");
    got = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (rsp_valid) got++;
    end
    check("no rsp in reset", got, 32'd0);
    reset_n = 1'b1;
    tick();
    check_job("post_reset", 0, 16'd9, 16'd6, 16'd3, 1'b0, -1);

    // Simultaneous requests 0 and 2 from rr_ptr=0.
    do_reset();
    req_a[15:0] = 16'd21;  req_b[15:0] = 16'd14;
    req_a[47:32] = 16'd100; req_b[47:32] = 16'd75;
    req = 4'b0101;
    got = 0;
    for (int c = 0; c < 400 && got < 2; c++) begin
      tick();
      req = req & ~req_ack;
      if (rsp_valid) begin
        ids[got] = rsp_id; datas[got] = rsp_data; got++;
      end
    end
    check("pair count", got, 32'd2);
    check("pair first id", {30'd0, ids[0]}, 32'd0);
    check("pair first data", {16'd0, datas[0]}, 32'd7);
    check("pair second id", {30'd0, ids[1]}, 32'd2);
    check("pair second data", {16'd0, datas[1]}, 32'd25);
    tick();
    // rr_ptr should now be 3: with everyone requesting, 3 wins.
    req_a[63:48] = 16'd30; req_b[63:48] = 16'd20;
    req = 4'b1111;
    tick();
    check("rr after pair", {28'd0, req_ack}, 32'h8);
    req = '0;
    got = 0;
    do begin tick(); got++; end while (!rsp_valid && got < 400);
    check("rr after pair data", {16'd0, rsp_data}, 32'd10);
    tick();

    // Fairness with all four requesting continuously.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*16 +: 16] = 16'(6 * (i + 1));
      req_b[i*16 +: 16] = 16'd4;
    end
    for (int k = 0; k < 8; k++) exp_q.push_back(IDW'(k % NREQ));
    req = 4'b1111;
    grants = 0; resps = 0; gap = 0; max_gap = 0;
    for (int c = 0; c < 3000 && resps < 8; c++) begin
      tick();
      if (req_ack != '0) begin
        gid = 0;
        for (int k = 0; k < NREQ; k++) if (req_ack[k]) gid = k;
        if (exp_q.size() > 0) check($sformatf("grant %0d", grants), gid, {30'd0, exp_q.pop_front()});
        grants++;
        req = req & ~req_ack;
      end else begin
        req = 4'b1111;
      end
      if (grants > 0) begin
        if (!busy) gap++; else gap = 0;
        if (gap > max_gap) max_gap = gap;
      end
      if (rsp_valid) resps++;
    end
    req = '0;
    check("fair responses", resps, 32'd8);
    check("fair grants", grants, 32'd8);
    check("fair idle gap", max_gap, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
